// File: rtl/instr_fetch_stage_if.sv
// Decode-side handshake bundle for instr_fetch_stage.
// The fetch stage is the master: it presents {out_pc, out_instr} with out_valid,
// and decode answers with out_ready.
interface instr_fetch_stage_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 16
);

  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_pc;
  logic [DW-1:0] out_instr;

  modport master (
    output out_valid,
    output out_pc,
    output out_instr,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_pc,
    input  out_instr,
    output out_ready
  );

endinterface

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage around an external PC register.
// - Drives pc_next (PC register input) and imem_addr (= pc) combinationally.
// - ROM has a 1-cycle read latency; returning data is captured with its PC into
//   a DEPTH-entry FIFO that feeds decode over a valid/ready handshake.
// - A redirect loads redirect_pc, clears the FIFO, squashes the in-flight fetch
//   and spends one cycle in S_FLUSH.
// Optional build macro: FETCH_PERF_CNT_EN enables saturating 16-bit stall and
// redirect counters on perf_stall / perf_redir; otherwise both are tied to 0.
module instr_fetch_stage #(
  parameter int unsigned AW    = 8,
  parameter int unsigned DW    = 16,
  parameter int unsigned INC   = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [AW-1:0]       pc,
  output logic [AW-1:0]       pc_next,
  output logic [AW-1:0]       imem_addr,
  input  logic [DW-1:0]       imem_rdata,
  input  logic                redirect,
  input  logic [AW-1:0]       redirect_pc,
  instr_fetch_stage_if.master dec,
  output logic [15:0]         perf_stall,
  output logic [15:0]         perf_redir
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = CW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH
  } state_e;

  state_e        state_q, state_d;

  // FIFO storage and bookkeeping
  logic [AW-1:0] pc_mem_q    [DEPTH];
  logic [DW-1:0] instr_mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Outstanding ROM request
  logic          inflight_q, inflight_d;
  logic [AW-1:0] req_pc_q, req_pc_d;

  // Per-cycle control
  logic          redir;
  logic          pop;
  logic          push;
  logic          issue;
  logic          head_valid;
  logic [OW-1:0] occ_proj;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign imem_addr     = pc;
  assign head_valid    = (count_q != '0);
  assign dec.out_valid = head_valid;
  assign dec.out_pc    = pc_mem_q[rd_ptr_q];
  assign dec.out_instr = instr_mem_q[rd_ptr_q];

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; redirect outranks run in both active states
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (run) state_d = S_RUN;
      S_RUN: begin
        if (redir)     state_d = S_FLUSH;
        else if (!run) state_d = S_IDLE;
      end
      S_FLUSH: begin
        if (redir)     state_d = S_FLUSH;
        else if (run)  state_d = S_RUN;
        else           state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output / control decode: issue rule, squash, pc_next selection
  always_comb begin
    redir    = redirect && (state_q != S_IDLE);
    pop      = head_valid && dec.out_ready && !redir;
    push     = inflight_q && !redir;
    // Entries the FIFO will hold once the outstanding response lands;
    // pop implies count_q >= 1, so this never underflows.
    occ_proj = {1'b0, count_q} + OW'(inflight_q) - OW'(pop);
    issue    = (state_q == S_RUN) && !redir && (occ_proj <= OW'(DEPTH - 1));
    pc_next  = pc;
    if (redir) begin
      pc_next = redirect_pc;
    end else if (issue) begin
      pc_next = pc + AW'(INC);
    end
  end

  // Next values for request tracking and FIFO pointers
  always_comb begin
    inflight_d = issue;
    req_pc_d   = issue ? pc : req_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (redir) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Request tracking and FIFO pointer registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight_q <= 1'b0;
      req_pc_q   <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      inflight_q <= inflight_d;
      req_pc_q   <= req_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage write; reset to zero so the idle head reads 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[wr_ptr_q]    <= req_pc_q;
      instr_mem_q[wr_ptr_q] <= imem_rdata;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] redir_cnt_q;

  // Saturating stall / redirect counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      if ((state_q == S_RUN) && !issue && !redir && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      if (redir && (redir_cnt_q != '1)) begin
        redir_cnt_q <= redir_cnt_q + 16'd1;
      end
    end
  end

  assign perf_stall = stall_cnt_q;
  assign perf_redir = redir_cnt_q;
`else
  assign perf_stall = '0;
  assign perf_redir = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: models the PC register and a
// synchronous ROM (ROM[a] = 0x1000 + a), keeps a queue of expected PCs and
// compares every accepted {out_pc, out_instr} against it.
module tb_instr_fetch_stage;

  logic        clk;
  logic        reset;
  logic        run;
  logic [7:0]  pc;
  logic [7:0]  pc_next;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic [15:0] perf_stall;
  logic [15:0] perf_redir;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_q [$];
  logic [7:0] mon_e;

`ifdef FETCH_PERF_CNT_EN
  localparam int EXP_STALL = 3;
  localparam int EXP_REDIR = 2;
`else
  localparam int EXP_STALL = 0;
  localparam int EXP_REDIR = 0;
`endif

  instr_fetch_stage_if #(.AW(8), .DW(16)) dif ();

  instr_fetch_stage #(
    .AW(8), .DW(16), .INC(1), .DEPTH(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .pc         (pc),
    .pc_next    (pc_next),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .dec        (dif),
    .perf_stall (perf_stall),
    .perf_redir (perf_redir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC register
  always @(posedge clk or negedge reset) begin
    if (!reset) pc <= 8'h00;
    else        pc <= pc_next;
  end

  // Synchronous ROM
  always @(posedge clk) imem_rdata <= 16'h1000 + {8'h00, imem_addr};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Scoreboard consumer: every accepted transfer must match the queue head
  always @(negedge clk) begin
    if (reset && dif.out_valid && dif.out_ready && !redirect) begin
      if (exp_q.size() == 0) begin
        check("sb_spurious", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_pc", 32'(dif.out_pc), 32'(mon_e));
        check("out_instr", 32'(dif.out_instr), 32'h1000 + 32'(mon_e));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_seq(input logic [7:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(8'(int'(start) + i));
  endtask

  // Wait for the queue to empty, then drop ready before another transfer
  task automatic wait_drain(input string tag, input int max);
    int k = 0;
    while (exp_q.size() != 0 && k < max) begin
      tick(1);
      k++;
    end
    dif.out_ready = 1'b0;
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset         = 1'b0;
    run           = 1'b0;
    redirect      = 1'b0;
    redirect_pc   = 8'h00;
    dif.out_ready = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_valid", 32'(dif.out_valid), 32'd0);
    check("rst_out_pc", 32'(dif.out_pc), 32'd0);
    check("rst_out_instr", 32'(dif.out_instr), 32'd0);
    check("rst_pc_next", 32'(pc_next), 32'd0);
    check("rst_perf_stall", 32'(perf_stall), 32'd0);
    check("rst_perf_redir", 32'(perf_redir), 32'd0);

    // Streaming: latency and 1/cycle throughput
    @(posedge clk); #1;
    reset = 1'b1; run = 1'b1; dif.out_ready = 1'b1;
    expect_seq(8'h00, 10);
    tick(2);
    @(negedge clk);
    check("lat_pre_valid", 32'(dif.out_valid), 32'd0);
    tick(1);
    @(negedge clk);
    check("lat_first_valid", 32'(dif.out_valid), 32'd1);
    repeat (8) begin
      @(negedge clk);
      check("thru_valid", 32'(dif.out_valid), 32'd1);
    end
    wait_drain("drain_stream", 30);

    // FIFO fills under back-pressure, then reset mid-stream
    tick(3);
    @(negedge clk);
    check("full_valid", 32'(dif.out_valid), 32'd1);
    check("full_head", 32'(dif.out_pc), 32'h0A);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("mid_rst_valid", 32'(dif.out_valid), 32'd0);
    check("mid_rst_pc_next", 32'(pc_next), 32'd0);
    exp_q.delete();
    tick(1);

    // Back-pressure from the start
    reset = 1'b1; run = 1'b1; dif.out_ready = 1'b0;
    tick(8);
    @(negedge clk);
    check("bp_pc_next", 32'(pc_next), 32'h02);
    check("bp_head", 32'(dif.out_pc), 32'h00);
    check("bp_valid", 32'(dif.out_valid), 32'd1);
    @(posedge clk); #1;
    dif.out_ready = 1'b1;
    expect_seq(8'h00, 6);
    wait_drain("drain_bp", 30);

    // Redirect mid-stream: buffered and in-flight fetches dropped
    dif.out_ready = 1'b1;
    expect_seq(8'h06, 20);
    tick(2);
    redirect = 1'b1; redirect_pc = 8'h40;
    exp_q.delete();
    expect_seq(8'h40, 5);
    @(negedge clk);
    check("redir_pc_next", 32'(pc_next), 32'h40);
    tick(1);
    redirect = 1'b0;
    @(negedge clk);
    check("redir_bubble", 32'(dif.out_valid), 32'd0);
    wait_drain("drain_redir", 30);

    // Redirect during S_FLUSH: only the second target survives
    dif.out_ready = 1'b1;
    expect_seq(8'h45, 20);
    tick(1);
    redirect = 1'b1; redirect_pc = 8'h40;
    exp_q.delete();
    tick(1);
    redirect_pc = 8'h80;
    expect_seq(8'h80, 6);
    @(negedge clk);
    check("redir2_pc_next", 32'(pc_next), 32'h80);
    tick(1);
    redirect = 1'b0;
    @(negedge clk);
    check("redir2_bubble", 32'(dif.out_valid), 32'd0);
    wait_drain("drain_redir2", 30);

    // PC wrap 0xFF -> 0x00
    dif.out_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 8'hFC;
    exp_q.delete();
    expect_seq(8'hFC, 8);
    tick(1);
    redirect = 1'b0;
    begin
      int k = 0;
      while (pc != 8'hFF && k < 20) begin
        tick(1);
        k++;
      end
    end
    check("wrap_reach", 32'(pc), 32'hFF);
    @(negedge clk);
    check("wrap_pc_next", 32'(pc_next), 32'h00);
    wait_drain("drain_wrap", 30);

    // Performance counters: 2 redirects then 3 stall cycles
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    tick(1);
    reset = 1'b1; run = 1'b1; dif.out_ready = 1'b1;
    expect_seq(8'h00, 20);
    tick(5);
    redirect = 1'b1; redirect_pc = 8'h40;
    exp_q.delete();
    expect_seq(8'h40, 20);
    tick(1);
    redirect = 1'b0;
    tick(4);
    redirect = 1'b1; redirect_pc = 8'h80;
    exp_q.delete();
    expect_seq(8'h80, 20);
    tick(1);
    redirect = 1'b0;
    tick(4);
    dif.out_ready = 1'b0;
    exp_q.delete();
    tick(2);
    run = 1'b0;
    tick(3);
    @(negedge clk);
    check("perf_stall", 32'(perf_stall), 32'(EXP_STALL));
    check("perf_redir", 32'(perf_redir), 32'(EXP_REDIR));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
